// File: rtl/adder_64b_if.sv
// Operand/result bundle for the registered 64-bit adder/subtractor.
// The master drives operands and consumes results; the adder is the slave.
interface adder_64b_if;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        in_valid;
    logic [63:0] s;
    logic        c_o;
    logic        out_valid;

    modport master (
        output a, b, sub, in_valid,
        input  s, c_o, out_valid
    );

    modport slave (
        input  a, b, sub, in_valid,
        output s, c_o, out_valid
    );
endinterface

// File: rtl/adder_64b.sv
// Registered 64-bit add/subtract built from a two-level 4-bit carry-lookahead tree.
// One-cycle latency, one operation per clock; carry-out is bit 64 of the exact sum.
module adder_64b (
    input  logic        clk,
    input  logic        rst_n,
    adder_64b_if.slave  bus
);

    // Group generate: carry out of a 4-bit slice assuming zero carry-in.
    function automatic logic la_gen(input logic [3:0] g, input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Internal carries c1..c3 of a 4-wide lookahead block, flattened to sum-of-products.
    function automatic logic [2:0] la_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic ci);
        logic c1, c2, c3;
        c1 = g[0] | (p[0] & ci);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        return {c3, c2, c1};
    endfunction

    function automatic logic la_cout(input logic [3:0] g, input logic [3:0] p,
                                     input logic ci);
        return la_gen(g, p) | ((&p) & ci);
    endfunction

    logic [63:0] bx;
    logic [63:0] bit_g;
    logic [63:0] bit_p;
    logic [15:0] grp_g;
    logic [15:0] grp_p;
    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic [3:0]  blk_c;
    logic [15:0] grp_c;
    logic [63:0] bit_c;
    logic [63:0] s_next;
    logic        c_o_next;

    logic [63:0] s_d, s_q;
    logic        c_o_d, c_o_q;
    logic        out_valid_d, out_valid_q;

    always_comb begin
        bx       = bus.b ^ {64{bus.sub}};
        bit_g    = bus.a & bx;
        bit_p    = bus.a ^ bx;
        grp_g    = '0;
        grp_p    = '0;
        blk_g    = '0;
        blk_p    = '0;
        grp_c    = '0;
        bit_c    = '0;

        for (int grp = 0; grp < 16; grp++) begin
            grp_g[grp] = la_gen(bit_g[4*grp +: 4], bit_p[4*grp +: 4]);
            grp_p[grp] = &bit_p[4*grp +: 4];
        end

        for (int blk = 0; blk < 4; blk++) begin
            blk_g[blk] = la_gen(grp_g[4*blk +: 4], grp_p[4*blk +: 4]);
            blk_p[blk] = &grp_p[4*blk +: 4];
        end

        // Top level: subtract enters as the carry-in of the whole tree.
        blk_c    = {la_carry(blk_g, blk_p, bus.sub), bus.sub};
        c_o_next = la_cout(blk_g, blk_p, bus.sub);

        for (int blk = 0; blk < 4; blk++) begin
            grp_c[4*blk +: 4] = {la_carry(grp_g[4*blk +: 4], grp_p[4*blk +: 4], blk_c[blk]),
                                 blk_c[blk]};
        end

        for (int grp = 0; grp < 16; grp++) begin
            bit_c[4*grp +: 4] = {la_carry(bit_g[4*grp +: 4], bit_p[4*grp +: 4], grp_c[grp]),
                                 grp_c[grp]};
        end

        s_next = bit_p ^ bit_c;
    end

    always_comb begin
        s_d         = s_q;
        c_o_d       = c_o_q;
        out_valid_d = bus.in_valid;
        if (bus.in_valid) begin
            s_d   = s_next;
            c_o_d = c_o_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '0;
            c_o_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            c_o_q       <= c_o_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.s         = s_q;
    assign bus.c_o       = c_o_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_64b.sv
// Scoreboard bench for adder_64b: directed corner cases, mid-run reset, and a
// randomized run with idle cycles checked against a 65-bit arithmetic model.
module tb_adder_64b;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    adder_64b_if bus ();

    adder_64b dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [64:0] exp_q[$];
    logic [64:0] held = '0;
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic sub);
        logic [64:0] bx;
        bx = {1'b0, (sub ? ~b : b)};
        return {1'b0, a} + bx + {64'd0, sub};
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops an expected result whenever the DUT presents one, otherwise
    // requires the output register to be holding the last captured value.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_out: got out_valid=1 expected no result at %0t", $time);
            end else begin
                held = exp_q.pop_front();
                check("result", {bus.c_o, bus.s}, held);
            end
        end else begin
            check("idle_valid", {64'd0, bus.out_valid}, 65'd0);
            check("hold", {bus.c_o, bus.s}, held);
        end
    end

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic sub,
                         input logic v, input logic [64:0] exp);
        @(posedge clk);
        #1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = sub;
        bus.in_valid = v;
        if (v) exp_q.push_back(exp);
    endtask

    task automatic issue_model(input logic [63:0] a, input logic [63:0] b, input logic sub);
        issue(a, b, sub, 1'b1, model(a, b, sub));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] ra, rb;
        logic        rs;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.in_valid = 1'b0;
        #2;
        check("reset_state", {bus.out_valid, bus.c_o, bus.s[62:0]}, 65'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, {1'b1, 64'h0});
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, {1'b0, 64'h8000_0000_0000_0000});
        issue(64'd5, 64'd3, 1'b1, 1'b1, {1'b1, 64'd2});
        issue(64'd0, 64'd0, 1'b1, 1'b1, {1'b1, 64'd0});
        issue(64'd3, 64'd5, 1'b1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE});
        issue(64'd0, 64'd1, 1'b1, 1'b1, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
        issue(64'h0FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1, {1'b0, 64'h1000_0000_0000_0000});
        issue(64'h1234, 64'h9999, 1'b1, 1'b0, 65'd0);
        issue(64'hDEAD_BEEF_0000_0001, 64'hFFFF, 1'b1, 1'b0, 65'd0);

        // Mid-run reset while an operation is being presented.
        issue(64'd100, 64'd23, 1'b0, 1'b1, 65'd123);
        #1 rst_n = 1'b0;
        #1;
        check("reset_async", {bus.out_valid, bus.c_o, bus.s[62:0]}, 65'd0);
        exp_q.delete();
        held = '0;
        issue(64'd7, 64'd8, 1'b0, 1'b1, 65'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) issue(64'($urandom), 64'($urandom), 1'b0, 1'b0, 65'd0);
        issue_model(64'd9, 64'd10, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            ra = {32'($urandom), 32'($urandom)};
            rb = {32'($urandom), 32'($urandom)};
            rs = 1'($urandom);
            if (($urandom % 8) == 0) rb = ~ra + 64'(rs);
            issue_model(ra, rb, rs);
            if (($urandom % 8) == 0)
                issue({32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                      1'($urandom), 1'b0, 65'd0);
        end

        issue(64'd0, 64'd0, 1'b0, 1'b0, 65'd0);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 65'(exp_q.size()), 65'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
